// File: rtl/hs_receiver_fifo_pkg.sv
// Shared definitions for the four-phase receiver with FIFO buffering.
// Holds the handshake FSM state encoding and the default sizing constants.
package hs_receiver_fifo_pkg;

   typedef enum logic {
      HS_IDLE     = 1'b0,
      HS_ACK_HOLD = 1'b1
   } hs_state_t;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_BURST_LEN = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with an explicit occupancy counter.
// Storage contents are not cleared on reset; dout reads as zero while empty.
module sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
)(
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          din,
   output logic [DATA_W-1:0]          dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/hs_receiver_fifo.sv
// Four-phase Request/Ack receiver feeding a FIFO, presented downstream as valid/ready.
// Pulses BurstDone the cycle after every BURST_LEN-th captured word.
module hs_receiver_fifo
   import hs_receiver_fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int BURST_LEN = DEF_BURST_LEN
)(
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       Request,
   input  logic [DATA_W-1:0]          DataIn,
   output logic                       Ack,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [DATA_W-1:0]          DataOut,
   output logic [$clog2(DEPTH+1)-1:0] Level,
   output logic                       BurstDone
);

   localparam int BC_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

   hs_state_t         state;
   logic [BC_W-1:0]   burst_cnt;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;

   // A word is taken only on the IDLE edge; a full FIFO simply withholds Ack.
   assign push     = (state == HS_IDLE) && Request && !fifo_full;
   assign pop      = OutReady && !fifo_empty;
   assign OutValid = !fifo_empty;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .Reset (Reset),
      .push  (push),
      .pop   (pop),
      .din   (DataIn),
      .dout  (DataOut),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (Level)
   );

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state     <= HS_IDLE;
         Ack       <= 1'b0;
         BurstDone <= 1'b0;
         burst_cnt <= '0;
      end else begin
         BurstDone <= 1'b0;
         case (state)
            HS_IDLE: begin
               if (Request && !fifo_full) begin
                  Ack   <= 1'b1;
                  state <= HS_ACK_HOLD;
                  if (burst_cnt == BC_W'(BURST_LEN - 1)) begin
                     burst_cnt <= '0;
                     BurstDone <= 1'b1;
                  end else begin
                     burst_cnt <= burst_cnt + BC_W'(1);
                  end
               end
            end
            HS_ACK_HOLD: begin
               if (!Request) begin
                  Ack   <= 1'b0;
                  state <= HS_IDLE;
               end
            end
            default: begin
               Ack   <= 1'b0;
               state <= HS_IDLE;
            end
         endcase
      end
   end

endmodule
